// File: rtl/fifo_wr_packer_if.sv
// Byte-stream input and FIFO write port of the write-side packer.
// The master side produces beats and models the FIFO's full flag; the slave side is the packer.
interface fifo_wr_packer_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
);
    localparam int unsigned CNT_W     = $clog2(RATIO);
    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO + CNT_W + 1;

    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 fifo_wr_en;
    logic [OUT_WIDTH-1:0] fifo_wr_data;
    logic                 fifo_full;

    modport master (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats into one tagged word for the dual-clock FIFO write port,
// with lossless backpressure on fifo_full and an idle flush of partial words.
module fifo_wr_packer #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned CNT_W     = $clog2(RATIO),
    parameter int unsigned OUT_WIDTH = IN_WIDTH * RATIO + CNT_W + 1,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned PKT_CNT_W = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst_n,
    fifo_wr_packer_if.slave      bus,
    output logic [PKT_CNT_W-1:0] pkt_count,
    output logic                 busy
);
    localparam int unsigned DATA_W = IN_WIDTH * RATIO;
    localparam int unsigned TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LANE_MAX = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]     lane_q, lane_d;
    logic [DATA_W-1:0]    acc_q, acc_d, acc_merged;
    logic                 out_pending_q, out_pending_d;
    logic [OUT_WIDTH-1:0] out_reg_q, out_reg_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

    logic stage_free, accept, complete, flush, wr_fire;

    assign stage_free = ~out_pending_q | ~bus.fifo_full;
    assign accept     = bus.in_valid & stage_free;
    assign complete   = accept & ((lane_q == LANE_MAX) | bus.in_last);
    assign wr_fire    = out_pending_q & ~bus.fifo_full;
    // A beat accepted in the flush cycle takes priority over the flush.
    assign flush      = (TIMEOUT != 0) & (lane_q != '0) & (timer_q == TMR_MAX) & stage_free
                        & ~accept;

    always_comb begin
        acc_merged = acc_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane_q == CNT_W'(i)) begin
                acc_merged[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            end
        end
    end

    always_comb begin
        lane_d        = lane_q;
        acc_d         = acc_q;
        out_reg_d     = out_reg_q;
        out_pending_d = out_pending_q & ~wr_fire;
        timer_d       = timer_q;
        pkt_count_d   = pkt_count_q;

        if (complete) begin
            out_reg_d     = {bus.in_last, lane_q, acc_merged};
            out_pending_d = 1'b1;
            lane_d        = '0;
            acc_d         = '0;
        end else if (accept) begin
            acc_d  = acc_merged;
            lane_d = lane_q + CNT_W'(1);
        end else if (flush) begin
            out_reg_d     = {1'b0, lane_q - CNT_W'(1), acc_q};
            out_pending_d = 1'b1;
            lane_d        = '0;
            acc_d         = '0;
        end

        if (accept || flush || (lane_q == '0) || (TIMEOUT == 0)) begin
            timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + TMR_W'(1);
        end

        if (wr_fire && out_reg_q[OUT_WIDTH-1]) begin
            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q        <= '0;
            acc_q         <= '0;
            out_pending_q <= 1'b0;
            out_reg_q     <= '0;
            timer_q       <= '0;
            pkt_count_q   <= '0;
        end else begin
            lane_q        <= lane_d;
            acc_q         <= acc_d;
            out_pending_q <= out_pending_d;
            out_reg_q     <= out_reg_d;
            timer_q       <= timer_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign bus.in_ready     = stage_free;
    assign bus.fifo_wr_en   = wr_fire;
    assign bus.fifo_wr_data = out_reg_q;
    assign pkt_count        = pkt_count_q;
    assign busy             = (lane_q != '0) | out_pending_q;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: queue-based packing model checked every cycle, directed
// scenarios pinned with literal words, then a randomized stream with idle and full bursts.
module tb_fifo_wr_packer;
    localparam int unsigned IN_WIDTH  = 8;
    localparam int unsigned RATIO     = 4;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned PKT_CNT_W = 16;
    localparam int unsigned OUT_WIDTH = 35;

    logic                 wr_clk = 1'b0;
    logic                 rst_n  = 1'b0;
    logic [PKT_CNT_W-1:0] pkt_count;
    logic                 busy;

    fifo_wr_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

    fifo_wr_packer #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO),
        .TIMEOUT  (TIMEOUT),
        .PKT_CNT_W(PKT_CNT_W)
    ) dut (
        .wr_clk   (wr_clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pkt_count(pkt_count),
        .busy     (busy)
    );

    always #5 wr_clk = ~wr_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: bytes of the open word, the word waiting for the FIFO, idle count, packets.
    logic [7:0]           m_part[$];
    bit                   m_pend;
    logic [OUT_WIDTH-1:0] m_word;
    int                   m_timer;
    logic [PKT_CNT_W-1:0] m_pkt;
    logic [OUT_WIDTH-1:0] m_log[$];
    logic [OUT_WIDTH-1:0] d_log[$];
    bit                   m_free, m_acc, m_wr, m_next_pend;

    function automatic logic [OUT_WIDTH-1:0] pack(input logic [7:0] b[$], input bit last);
        logic [31:0] d;
        d = '0;
        foreach (b[i]) d = d | (32'(b[i]) << (8 * i));
        return {last, 2'(b.size() - 1), d};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic chk_word(input string name, input int idx, input logic [OUT_WIDTH-1:0] want);
        if (idx >= m_log.size() || idx >= d_log.size()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got %0d model / %0d dut words, want more than %0d",
                     name, m_log.size(), d_log.size(), idx);
        end else begin
            check({name, "_model"}, 64'(m_log[idx]), 64'(want));
            check({name, "_dut"}, 64'(d_log[idx]), 64'(want));
        end
    endtask

    always @(posedge wr_clk) cyc++;

    always @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_part.delete();
            m_pend  = 1'b0;
            m_word  = '0;
            m_timer = 0;
            m_pkt   = '0;
        end else begin
            m_free      = !m_pend || !bus.fifo_full;
            m_acc       = bus.in_valid && m_free;
            m_wr        = m_pend && !bus.fifo_full;
            m_next_pend = m_pend && !m_wr;
            if (m_wr) begin
                m_log.push_back(m_word);
                if (m_word[OUT_WIDTH-1]) m_pkt = m_pkt + 1'b1;
            end
            if (m_acc) begin
                m_part.push_back(bus.in_data);
                m_timer = 0;
                if (m_part.size() == RATIO || bus.in_last) begin
                    m_word = pack(m_part, bus.in_last);
                    m_part.delete();
                    m_next_pend = 1'b1;
                end
            end else if (m_part.size() == 0) begin
                m_timer = 0;
            end else if (m_timer == TIMEOUT) begin
                if (m_free) begin
                    m_word = pack(m_part, 1'b0);
                    m_part.delete();
                    m_timer = 0;
                    m_next_pend = 1'b1;
                end
            end else begin
                m_timer++;
            end
            m_pend = m_next_pend;
        end
    end

    always @(negedge wr_clk) begin
        if (rst_n) begin
            check("in_ready", 64'(bus.in_ready), 64'(!m_pend || !bus.fifo_full));
            check("fifo_wr_en", 64'(bus.fifo_wr_en), 64'(m_pend && !bus.fifo_full));
            check("busy", 64'(busy), 64'(m_part.size() != 0 || m_pend));
            check("pkt_count", 64'(pkt_count), 64'(m_pkt));
            if (m_pend) check("fifo_wr_data", 64'(bus.fifo_wr_data), 64'(m_word));
            if (bus.fifo_wr_en) d_log.push_back(bus.fifo_wr_data);
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge wr_clk);
            ok = bus.in_ready;
            tick();
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: beat %0h got in_ready=0, want 1 within 200 cycles", d);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin : main
        int at;
        int c0;
        int base;
        logic [PKT_CNT_W-1:0] pk0;
        bit idle;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1 rst_n = 1'b1;
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_pkt_count", 64'(pkt_count), 64'd0);
        check("reset_wr_en", 64'(bus.fifo_wr_en), 64'd0);

        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        repeat (3) tick();
        chk_word("full_word", 0, 35'h7_4433_2211);
        check("full_pkt_count", 64'(pkt_count), 64'd1);

        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
        repeat (3) tick();
        chk_word("short_word", 1, 35'h6_00CC_BBAA);
        check("short_pkt_count", 64'(pkt_count), 64'd2);

        bus.fifo_full = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(8'h21 + i), i == 7);
            end
            begin
                repeat (20) tick();
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_held_words", 64'(d_log.size()), 64'd2);
                bus.fifo_full = 1'b0;
            end
        join
        repeat (4) tick();
        chk_word("bp_word_a", 2, 35'h3_2423_2221);
        chk_word("bp_word_b", 3, 35'h7_2827_2625);
        check("bp_pkt_count", 64'(pkt_count), 64'd3);

        // Flush decision is taken in the cycle the timer sits at TIMEOUT.
        send(8'h01, 1'b0); send(8'h02, 1'b0);
        at = 0;
        for (int k = 1; k <= 40 && at == 0; k++) begin
            @(negedge wr_clk);
            if (bus.fifo_wr_en) at = k;
            tick();
        end
        check("timeout_latency", 64'(at), 64'd18);
        repeat (2) tick();
        chk_word("timeout_word", 4, 35'h1_0000_0201);
        check("timeout_pkt_count", 64'(pkt_count), 64'd3);

        repeat (3) tick();
        send(8'h03, 1'b0); send(8'h04, 1'b0);
        repeat (16) tick();
        send(8'h05, 1'b1);
        repeat (3) tick();
        chk_word("cancel_word", 5, 35'h6_0005_0403);
        check("cancel_word_count", 64'(d_log.size()), 64'd6);
        check("cancel_pkt_count", 64'(pkt_count), 64'd4);

        send(8'h91, 1'b0); send(8'h92, 1'b0); send(8'h93, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b1);
        repeat (3) tick();
        chk_word("post_reset_word", 6, 35'h7_8877_6655);
        check("post_reset_pkt_count", 64'(pkt_count), 64'd1);

        c0   = cyc;
        base = d_log.size();
        pk0  = pkt_count;
        for (int i = 0; i < 64; i++) send(8'($urandom), (i % 8) == 7);
        check("stream_cycles", 64'(cyc - c0), 64'd64);
        repeat (3) tick();
        check("stream_words", 64'(d_log.size() - base), 64'd16);
        check("stream_pkts", 64'(PKT_CNT_W'(pkt_count - pk0)), 64'd8);

        for (int c = 0; c < 3000; c++) begin
            idle          = (c % 300) >= 260;
            bus.in_valid  = !idle && ($urandom_range(3) != 0);
            bus.in_data   = 8'($urandom);
            bus.in_last   = ($urandom_range(6) == 0);
            bus.fifo_full = ((c % 500) >= 100 && (c % 500) < 130) || ($urandom_range(3) == 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (40) tick();
        check("final_word_count", 64'(d_log.size()), 64'(m_log.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
